xnor_lane_seq: RTL
==================

XNOR_LANE_SEQ -- requirements
Module: xnor_lane_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit count; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  frame request; accepted only in IDLE.
REQ-005 SHALL have port mode  input  2  gate select: 00 XNOR, 01 XOR, 10 AND, 11 OR; sampled on the accepted start.
REQ-006 SHALL have port a_in  input  1  serial operand A, LSB first.
REQ-007 SHALL have port b_in  input  1  serial operand B, LSB first.
REQ-008 SHALL have port y_out  output  1  serial result, LSB first.
REQ-009 SHALL have port y_valid  output  1  high while y_out carries a result bit.
REQ-010 SHALL have port busy  output  1  high in LOAD, EVAL and SHIFT.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, EVAL, SHIFT.
REQ-013 IDLE -> LOAD when start=1 in IDLE; mode latched in that cycle (cycle 0).
REQ-014 LOAD: a_in/b_in sampled in cycles 1..WIDTH, bit k in cycle k+1; bit counter wraps to 0 on leaving LOAD.
REQ-015 LOAD -> EVAL after WIDTH samples; EVAL lasts one cycle (cycle WIDTH+1) and registers result = A op B bitwise per latched mode.
REQ-016 EVAL -> SHIFT; y_valid=1 and y_out=result[k] in cycle WIDTH+2+k, k=0..WIDTH-1.
REQ-017 SHIFT -> IDLE after last bit; done=1 in cycle 2*WIDTH+2 (first IDLE cycle) only.
REQ-018 y_out SHALL be 0 whenever y_valid=0.
REQ-019 start while busy=1 SHALL be ignored; mode changes while busy SHALL not affect the frame.
REQ-020 start in the done cycle SHALL be accepted; done and the new LOAD entry coexist.
REQ-021 a_in/b_in values outside LOAD SHALL have no effect.

Reset
REQ-022 reset=1 SHALL force IDLE immediately regardless of clk, from any state including mid-LOAD/SHIFT.
REQ-023 Reset values: y_out=0, y_valid=0, busy=0, done=0, operand/result registers 0, latched mode 00, bit counter 0, ones=0.
REQ-024 A frame interrupted by reset SHALL be discarded; no done pulse after reset release.

Configuration
REQ-025 Macro XNOR_LANE_POPCOUNT_EN, when defined, SHALL add output ones, width clog2(WIDTH+1), = count of 1 bits in result.
REQ-026 With macro: ones SHALL update in the cycle after EVAL and hold until the next EVAL or reset.
REQ-027 Without macro: port ones and its counter logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 mode=00, A=0xA5, B=0x5A -> y_out bits give 0x00, y_valid cycles 10..17, done at cycle 18; ones=0.
REQ-029 mode=01, A=0xA5, B=0x5A -> result 0xFF; ones=8 (macro defined).
REQ-030 mode=10, A=0xF0, B=0x3C -> 0x30; mode=11 same operands -> 0xFC, ones=6.
REQ-031 reset pulsed in LOAD cycle 4 -> busy=0 next cycle, no y_valid, no done; following frame A=0x01,B=0x01,mode=10 -> 0x01.
REQ-032 start held high through frame -> exactly one frame until done cycle, then a second frame starts in the done cycle.
REQ-033 mode toggled every cycle during busy -> result uses mode sampled at cycle 0.

Source files
------------

// File: rtl/xnor_lane_seq.sv
// Bit-serial two-operand logic lane.
// A frame loads WIDTH bits of A and B (LSB first), evaluates one bitwise gate
// chosen by the mode latched at start, then shifts the WIDTH-bit result out
// LSB first with y_valid, followed by a one-cycle done pulse.
// Optional feature: define XNOR_LANE_POPCOUNT_EN to add the 'ones' output,
// the population count of the last evaluated result.
module xnor_lane_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic                           a_in,
  input  logic                           b_in,
  output logic                           y_out,
  output logic                           y_valid,
  output logic                           busy,
`ifdef XNOR_LANE_POPCOUNT_EN
  output logic                           done,
  output logic [$clog2(WIDTH+1)-1:0]     ones
`else
  output logic                           done
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StEval  = 2'd2,
    StShift = 2'd3
  } state_e;

  // Gate encodings as seen on the mode input.
  localparam logic [1:0] ModeXnor = 2'b00;
  localparam logic [1:0] ModeXor  = 2'b01;
  localparam logic [1:0] ModeAnd  = 2'b10;
  localparam logic [1:0] ModeOr   = 2'b11;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  op_res;

  // Bitwise gate on the fully loaded operands, selected by the latched mode.
  always_comb begin
    op_res = '0;
    unique case (mode_q)
      ModeXnor: op_res = ~(a_q ^ b_q);
      ModeXor:  op_res = a_q ^ b_q;
      ModeAnd:  op_res = a_q & b_q;
      ModeOr:   op_res = a_q | b_q;
      default:  op_res = '0;
    endcase
  end

  // Next-state logic: frame sequencing, operand capture and result shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Also taken in the done cycle, so back-to-back frames need no gap.
        if (start) begin
          mode_d  = mode;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Shift in from the top so bit k ends up at index k after WIDTH samples.
        a_d = {a_in, a_q[WIDTH-1:1]};
        b_d = {b_in, b_q[WIDTH-1:1]};
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEval: begin
        res_d   = op_res;
        state_d = StShift;
      end
      StShift: begin
        // res_q[0] is on y_out this cycle; expose the next bit for the next one.
        res_d = {1'b0, res_q[WIDTH-1:1]};
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    busy    = (state_q != StIdle);
    y_valid = (state_q == StShift);
    y_out   = y_valid & res_q[0];
    done    = done_q;
  end

`ifdef XNOR_LANE_POPCOUNT_EN
  localparam int unsigned OnesW = $clog2(WIDTH + 1);

  logic [OnesW-1:0] ones_q, ones_d;
  logic [OnesW-1:0] pop_cnt;

  // Population count of the gate result, captured together with it in EVAL.
  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + OnesW'(op_res[i]);
    end
    ones_d = ones_q;
    if (state_q == StEval) begin
      ones_d = pop_cnt;
    end
  end

  // Count register holds until the next EVAL or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones = ones_q;
`endif

endmodule
